// File: rtl/mem_stage_dmem_pkg.sv
// Shared opcodes, access-type codes and lane helpers for the MEM-stage data memory.
package mem_stage_dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [2:0] LS_WORD  = 3'd0;
    localparam logic [2:0] LS_HALF  = 3'd1;
    localparam logic [2:0] LS_HALFU = 3'd2;
    localparam logic [2:0] LS_BYTE  = 3'd3;
    localparam logic [2:0] LS_BYTEU = 3'd4;

    // Byte-lane enable for an access; unused codes behave as a full word.
    function automatic logic [3:0] lane_be(input logic [2:0] ls, input logic [1:0] a);
        logic [3:0] be;
        case (ls)
            LS_HALF, LS_HALFU: be = a[1] ? 4'b1100 : 4'b0011;
            LS_BYTE, LS_BYTEU: be = 4'b0001 << a;
            default:           be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
interface mem_stage_dmem_if;

    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        MemWrite;
    logic [2:0]  LStype;

    modport master (
        output Instr, PC, Addr, WD,
        input  RD, MemWrite, LStype
    );

    modport slave (
        input  Instr, PC, Addr, WD,
        output RD, MemWrite, LStype
    );

endinterface

// File: rtl/mem_stage_dmem_op_decode.sv
// Combinational load/store decoder: opcode field to store enable and access type.
module mem_op_decode
    import mem_stage_dmem_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        mem_write_o,
    output logic [2:0]  ls_type_o
);

    logic [5:0] op;
    logic       unused_instr;

    assign op           = instr_i[31:26];
    assign unused_instr = ^instr_i[25:0];

    always_comb begin
        mem_write_o = 1'b0;
        ls_type_o   = LS_WORD;
        case (op)
            OP_SW:  begin mem_write_o = 1'b1; ls_type_o = LS_WORD; end
            OP_SH:  begin mem_write_o = 1'b1; ls_type_o = LS_HALF; end
            OP_SB:  begin mem_write_o = 1'b1; ls_type_o = LS_BYTE; end
            OP_LW:  ls_type_o = LS_WORD;
            OP_LH:  ls_type_o = LS_HALF;
            OP_LHU: ls_type_o = LS_HALFU;
            OP_LB:  ls_type_o = LS_BYTE;
            OP_LBU: ls_type_o = LS_BYTEU;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: lane-masked synchronous stores, combinational extended loads.
// Optional store trace enabled by defining DMEM_WRITE_TRACE_EN.
module mem_stage_dmem
    import mem_stage_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = 12
) (
    input logic               Clk,
    input logic               Reset,
    mem_stage_dmem_if.slave   bus_io
);

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       word_rd;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       word_merged;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic              unused_addr;

    // Upper address bits fall away, so accesses wrap modulo the array size.
    assign word_idx    = bus_io.Addr[ADDR_W+1:2];
    assign word_rd     = mem_q[word_idx];
    assign unused_addr = ^{bus_io.Addr[31:ADDR_W+2], bus_io.PC};

    mem_op_decode u_decode (
        .instr_i     (bus_io.Instr),
        .mem_write_o (bus_io.MemWrite),
        .ls_type_o   (bus_io.LStype)
    );

    always_comb begin
        be = lane_be(bus_io.LStype, bus_io.Addr[1:0]);
        case (bus_io.LStype)
            LS_HALF, LS_HALFU: wdata_rep = {2{bus_io.WD[15:0]}};
            LS_BYTE, LS_BYTEU: wdata_rep = {4{bus_io.WD[7:0]}};
            default:           wdata_rep = bus_io.WD;
        endcase
        for (int k = 0; k < 4; k++) begin
            word_merged[8*k +: 8] = be[k] ? wdata_rep[8*k +: 8] : word_rd[8*k +: 8];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus_io.MemWrite) begin
            mem_q[word_idx] <= word_merged;
        end
    end

    always_comb begin
        half_sel = bus_io.Addr[1] ? word_rd[31:16] : word_rd[15:0];
        case (bus_io.Addr[1:0])
            2'd0:    byte_sel = word_rd[7:0];
            2'd1:    byte_sel = word_rd[15:8];
            2'd2:    byte_sel = word_rd[23:16];
            default: byte_sel = word_rd[31:24];
        endcase
        case (bus_io.LStype)
            LS_HALF:  bus_io.RD = {{16{half_sel[15]}}, half_sel};
            LS_HALFU: bus_io.RD = {16'h0000, half_sel};
            LS_BYTE:  bus_io.RD = {{24{byte_sel[7]}}, byte_sel};
            LS_BYTEU: bus_io.RD = {24'h000000, byte_sel};
            default:  bus_io.RD = word_rd;
        endcase
    end

`ifdef DMEM_WRITE_TRACE_EN
    always @(posedge Clk) begin
        if (!Reset && bus_io.MemWrite) begin
            $display("@%h: *%h <= %h", bus_io.PC, {bus_io.Addr[31:2], 2'b00}, word_merged);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem: directed plan plus randomized ops vs a word-array model.
module tb_mem_stage_dmem;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] model_mem [4096];

    mem_stage_dmem_if bus ();

    mem_stage_dmem #(
        .DEPTH_WORDS (4096),
        .ADDR_W      (12)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .bus_io (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec decode table: returns {write, type}.
    function automatic logic [3:0] ref_decode(input logic [5:0] op);
        case (op)
            6'h2B:   return {1'b1, 3'd0};
            6'h29:   return {1'b1, 3'd1};
            6'h28:   return {1'b1, 3'd3};
            6'h23:   return {1'b0, 3'd0};
            6'h21:   return {1'b0, 3'd1};
            6'h25:   return {1'b0, 3'd2};
            6'h20:   return {1'b0, 3'd3};
            6'h24:   return {1'b0, 3'd4};
            default: return {1'b0, 3'd0};
        endcase
    endfunction

    function automatic int unsigned ref_idx(input logic [31:0] addr);
        return (addr / 4) % 4096;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ls, input logic [31:0] addr);
        logic [31:0] w;
        int unsigned v;
        w = model_mem[ref_idx(addr)];
        case (ls)
            3'd1, 3'd2: begin
                v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
                if (ls == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            3'd3, 3'd4: begin
                v = (w >> (8 * (addr % 4))) & 32'hFF;
                if (ls == 3'd3 && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] ls, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned sh;
        int unsigned mask;
        int unsigned i;
        i = ref_idx(addr);
        if (ls == 3'd1) begin
            sh = 16 * ((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            model_mem[i] = (model_mem[i] & ~mask) | ((wd & 32'hFFFF) << sh);
        end else if (ls == 3'd3) begin
            sh = 8 * (addr % 4);
            mask = 32'hFF << sh;
            model_mem[i] = (model_mem[i] & ~mask) | ((wd & 32'hFF) << sh);
        end else begin
            model_mem[i] = wd;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
    endtask

    // Drive one op in the low phase, check outputs, then take one edge.
    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic [3:0]  dec;
        logic [31:0] lo;
        lo = $urandom() & 32'h03FF_FFFF;
        bus.Instr = {op, lo[25:0]};
        bus.Addr  = addr;
        bus.WD    = wd;
        bus.PC    = 32'h3000;
        dec = ref_decode(op);
        #1;
        check({tag, ".MemWrite"}, {31'b0, bus.MemWrite}, {31'b0, dec[3]});
        check({tag, ".LStype"}, {29'b0, bus.LStype}, {29'b0, dec[2:0]});
        check({tag, ".RD"}, bus.RD, ref_load(dec[2:0], addr));
        @(posedge Clk);
        if (Reset) model_clear();
        else if (dec[3]) ref_store(dec[2:0], addr, wd);
        @(negedge Clk);
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] a;
        logic [31:0] r;
        ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h0F, 6'h00};
        bus.Instr = 32'h0;
        bus.PC    = 32'h0;
        bus.Addr  = 32'h0;
        bus.WD    = 32'h0;
        model_clear();

        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        do_op("rst_lw0", 6'h23, 32'h0, 32'h0);
        check("rst_lw0.const", bus.RD, 32'h0);
        do_op("rst_lw3ffc", 6'h23, 32'h3FFC, 32'h0);
        check("rst_lw3ffc.const", bus.RD, 32'h0);

        do_op("sw10", 6'h2B, 32'h10, 32'h80FF7F01);
        do_op("lw10", 6'h23, 32'h10, 32'h0);
        check("lw10.const", bus.RD, 32'h80FF7F01);
        do_op("lb10", 6'h20, 32'h10, 32'h0);
        check("lb10.const", bus.RD, 32'h00000001);
        do_op("lb11", 6'h20, 32'h11, 32'h0);
        check("lb11.const", bus.RD, 32'h0000007F);
        do_op("lb12", 6'h20, 32'h12, 32'h0);
        check("lb12.const", bus.RD, 32'hFFFFFFFF);
        do_op("lb13", 6'h20, 32'h13, 32'h0);
        check("lb13.const", bus.RD, 32'hFFFFFF80);
        do_op("lbu12", 6'h24, 32'h12, 32'h0);
        check("lbu12.const", bus.RD, 32'h000000FF);
        do_op("lh10", 6'h21, 32'h10, 32'h0);
        check("lh10.const", bus.RD, 32'h00007F01);
        do_op("lh12", 6'h21, 32'h12, 32'h0);
        check("lh12.const", bus.RD, 32'hFFFF80FF);
        do_op("lhu12", 6'h25, 32'h12, 32'h0);
        check("lhu12.const", bus.RD, 32'h000080FF);
        do_op("lh13", 6'h21, 32'h13, 32'h0);
        check("lh13.const", bus.RD, 32'hFFFF80FF);

        do_op("sw20", 6'h2B, 32'h20, 32'h11223344);
        do_op("sb21", 6'h28, 32'h21, 32'hAAAAAA55);
        do_op("lw20a", 6'h23, 32'h20, 32'h0);
        check("lw20a.const", bus.RD, 32'h11225544);
        do_op("sh22", 6'h29, 32'h22, 32'h0000BEEF);
        do_op("lw20b", 6'h23, 32'h20, 32'h0);
        check("lw20b.const", bus.RD, 32'hBEEF5544);

        do_op("sw4010", 6'h2B, 32'h4010, 32'hCAFEF00D);
        do_op("lw10alias", 6'h23, 32'h10, 32'h0);
        check("lw10alias.const", bus.RD, 32'hCAFEF00D);

        do_op("lui", 6'h0F, 32'h10, 32'h12345678);
        do_op("rtype", 6'h00, 32'h10, 32'h87654321);
        do_op("lw10keep", 6'h23, 32'h10, 32'h0);
        check("lw10keep.const", bus.RD, 32'hCAFEF00D);

        Reset = 1'b1;
        do_op("sw30rst", 6'h2B, 32'h30, 32'hDEADBEEF);
        Reset = 1'b0;
        do_op("lw30rst", 6'h23, 32'h30, 32'h0);
        check("lw30rst.const", bus.RD, 32'h0);
        do_op("lw10rst", 6'h23, 32'h10, 32'h0);
        check("lw10rst.const", bus.RD, 32'h0);

        do_op("sw6", 6'h2B, 32'h6, 32'h12345678);
        do_op("lw4", 6'h23, 32'h4, 32'h0);
        check("lw4.const", bus.RD, 32'h12345678);

        for (int n = 0; n < 400; n++) begin
            a = $urandom() & 32'hFFFF_C03F;
            r = $urandom();
            do_op("rand", ops[$urandom_range(0, 9)], a, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
